// File: rtl/branch_predictor_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : bp_types_pkg                                               |
// | Shared entry layout, counter constants and saturating step helper    |
// | for the branch_predictor BTB.                                        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package bp_types_pkg;

    localparam int c_max_ctr_w  = 4;
    localparam int c_def_word_w = 32;
    localparam int c_def_idx_w  = 4;
    localparam int c_def_ctr_w  = 2;
    localparam int c_def_tag_w  = c_def_word_w - c_def_idx_w - 2;

    typedef logic [c_max_ctr_w-1:0] bp_ctr_t;

    // Entry layout for the default geometry; the top re-derives it from its own parameters.
    typedef struct packed {
        logic                    valid;
        logic [c_def_tag_w-1:0]  tag;
        logic [c_def_word_w-1:0] target;
        logic [c_def_ctr_w-1:0]  ctr;
    } bp_entry_t;

    function automatic bp_ctr_t bp_ctr_reset_val(input int unsigned ctr_w);
        return bp_ctr_t'((1 << (ctr_w - 1)) - 1);
    endfunction

    function automatic bp_ctr_t bp_ctr_alloc_val(input int unsigned ctr_w);
        return bp_ctr_t'(1 << (ctr_w - 1));
    endfunction

    function automatic bp_ctr_t bp_sat_step(input bp_ctr_t ctr, input logic up,
                                            input int unsigned ctr_w);
        bp_ctr_t max_v;
        max_v = bp_ctr_t'((1 << ctr_w) - 1);
        if (up) begin
            return (ctr >= max_v) ? ctr : ctr + 1'b1;
        end
        return (ctr == '0) ? ctr : ctr - 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_predictor_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : branch_predictor_if                                      |
// | Fetch lookup and resolution update bundle for branch_predictor.      |
// | Optional statistics signals under BP_STATS_EN.                       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface branch_predictor_if #(
    parameter int WORD_W = 32
);
    logic [WORD_W-1:0] lookup_pc;
    logic              hit;
    logic              predict_taken;
    logic [WORD_W-1:0] predict_target;
    logic              update_en;
    logic [WORD_W-1:0] update_pc;
    logic              update_taken;
    logic [WORD_W-1:0] update_target;
    logic              update_mispredict;
    logic              invalidate;
`ifdef BP_STATS_EN
    logic [31:0]       stat_updates;
    logic [31:0]       stat_mispredicts;

    modport master (
        output lookup_pc, update_en, update_pc, update_taken, update_target,
               update_mispredict, invalidate,
        input  hit, predict_taken, predict_target, stat_updates, stat_mispredicts
    );
    modport slave (
        input  lookup_pc, update_en, update_pc, update_taken, update_target,
               update_mispredict, invalidate,
        output hit, predict_taken, predict_target, stat_updates, stat_mispredicts
    );
`else
    modport master (
        output lookup_pc, update_en, update_pc, update_taken, update_target,
               update_mispredict, invalidate,
        input  hit, predict_taken, predict_target
    );
    modport slave (
        input  lookup_pc, update_en, update_pc, update_taken, update_target,
               update_mispredict, invalidate,
        output hit, predict_taken, predict_target
    );
`endif
endinterface
`default_nettype wire

// File: rtl/branch_predictor_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : sat_counter                                                |
// | CTR_W-bit saturating direction counter with allocate load.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sat_counter
    import bp_types_pkg::*;
#(
    parameter int CTR_W = 2
) (
    input  wire logic             CLK,
    input  wire logic             nRST,
    input  wire logic             i_en,
    input  wire logic             i_up,
    input  wire logic             i_load,
    output logic [CTR_W-1:0]      o_count
);
    localparam logic [CTR_W-1:0] c_reset = CTR_W'(bp_ctr_reset_val(CTR_W));
    localparam logic [CTR_W-1:0] c_alloc = CTR_W'(bp_ctr_alloc_val(CTR_W));

    logic [CTR_W-1:0] r_count;
    logic [CTR_W-1:0] w_step;

    assign w_step = CTR_W'(bp_sat_step(bp_ctr_t'(r_count), i_up, CTR_W));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_count <= c_reset;
        end else if (i_load) begin
            r_count <= c_alloc;
        end else if (i_en) begin
            r_count <= w_step;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : branch_predictor                                           |
// | Direct-mapped BTB with per-entry saturating direction counters.      |
// | Optional macro BP_STATS_EN adds update/mispredict statistics.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module branch_predictor
    import bp_types_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int WORD_W  = 32
) (
    input  wire logic        CLK,
    input  wire logic        nRST,
    branch_predictor_if.slave bp
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = WORD_W - IDX_W - 2;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [WORD_W-1:0] target;
    } entry_t;

    entry_t           w_entry [ENTRIES];
    logic [CTR_W-1:0] w_ctr   [ENTRIES];

    logic [IDX_W-1:0] w_lu_idx;
    logic [TAG_W-1:0] w_lu_tag;
    logic [IDX_W-1:0] w_up_idx;
    logic [TAG_W-1:0] w_up_tag;
    entry_t           w_lu_entry;
    entry_t           w_up_entry;
    logic             w_lu_hit;
    logic             w_up_hit;
    logic             w_accept;
    logic             w_train;
    logic             w_alloc;

    assign w_lu_idx   = bp.lookup_pc[IDX_W+1:2];
    assign w_lu_tag   = bp.lookup_pc[WORD_W-1:IDX_W+2];
    assign w_up_idx   = bp.update_pc[IDX_W+1:2];
    assign w_up_tag   = bp.update_pc[WORD_W-1:IDX_W+2];
    assign w_lu_entry = w_entry[w_lu_idx];
    assign w_up_entry = w_entry[w_up_idx];

    // Lookup reads stored state only, so a same-cycle update is never bypassed.
    assign w_lu_hit = w_lu_entry.valid && (w_lu_entry.tag == w_lu_tag);
    assign w_up_hit = w_up_entry.valid && (w_up_entry.tag == w_up_tag);

    assign bp.hit            = w_lu_hit;
    assign bp.predict_taken  = w_lu_hit && w_ctr[w_lu_idx][CTR_W-1];
    assign bp.predict_target = w_lu_hit ? w_lu_entry.target : '0;

    assign w_accept = bp.update_en && !bp.invalidate;
    assign w_train  = w_accept && w_up_hit;
    assign w_alloc  = w_accept && !w_up_hit && bp.update_taken;

    for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
        entry_t r_entry;
        logic   w_sel;

        assign w_sel = (w_up_idx == IDX_W'(i));

        sat_counter #(
            .CTR_W (CTR_W)
        ) u_ctr (
            .CLK     (CLK),
            .nRST    (nRST),
            .i_en    (w_train && w_sel),
            .i_up    (bp.update_taken),
            .i_load  (w_alloc && w_sel),
            .o_count (w_ctr[i])
        );

        always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
                r_entry <= '0;
            end else if (bp.invalidate) begin
                r_entry.valid <= 1'b0;
            end else if (w_accept && w_sel && bp.update_taken) begin
                r_entry.target <= bp.update_target;
                if (!w_up_hit) begin
                    r_entry.valid <= 1'b1;
                    r_entry.tag   <= w_up_tag;
                end
            end
        end

        assign w_entry[i] = r_entry;
    end

`ifdef BP_STATS_EN
    logic [31:0] r_stat_updates;
    logic [31:0] r_stat_mispredicts;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_stat_updates     <= '0;
            r_stat_mispredicts <= '0;
        end else if (w_accept) begin
            r_stat_updates <= r_stat_updates + 32'd1;
            if (bp.update_mispredict) begin
                r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
            end
        end
    end

    assign bp.stat_updates     = r_stat_updates;
    assign bp.stat_mispredicts = r_stat_mispredicts;

    logic w_unused;
    assign w_unused = ^{bp.lookup_pc[1:0], bp.update_pc[1:0]};
`else
    // Byte-offset bits and the mispredict flag carry no state in this build.
    logic w_unused;
    assign w_unused = ^{bp.lookup_pc[1:0], bp.update_pc[1:0], bp.update_mispredict};
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_branch_predictor                                        |
// | Self-checking bench: vector table, corner sequences, random vs model.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_branch_predictor;
    localparam int ENTRIES = 16;
    localparam int CTR_W   = 2;
    localparam int WORD_W  = 32;
    localparam int IDX_W   = $clog2(ENTRIES);
    localparam int CTR_MAX = (1 << CTR_W) - 1;
    localparam int CTR_MID = 1 << (CTR_W - 1);

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    branch_predictor_if #(.WORD_W(WORD_W)) bpi ();

    branch_predictor #(
        .ENTRIES (ENTRIES),
        .CTR_W   (CTR_W),
        .WORD_W  (WORD_W)
    ) dut (
        .CLK  (clk),
        .nRST (nrst),
        .bp   (bpi)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: full-PC bookkeeping, modulo indexing, integer counters.
    bit          m_valid  [ENTRIES];
    logic [31:0] m_tag    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          m_ctr    [ENTRIES];
    int unsigned m_upd, m_mis;

    function automatic int m_index(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic logic [31:0] m_tagof(input logic [31:0] pc);
        return pc >> (2 + IDX_W);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0; m_tag[i] = '0; m_target[i] = '0; m_ctr[i] = CTR_MID - 1;
        end
        m_upd = 0; m_mis = 0;
    endtask

    task automatic model_update(input bit en, input bit inv, input logic [31:0] pc,
                                input bit taken, input logic [31:0] tgt, input bit mis);
        int i;
        i = m_index(pc);
        if (inv) begin
            for (int k = 0; k < ENTRIES; k++) m_valid[k] = 0;
        end else if (en) begin
            m_upd++;
            if (mis) m_mis++;
            if (m_valid[i] && m_tag[i] == m_tagof(pc)) begin
                if (taken) begin
                    m_ctr[i] = (m_ctr[i] < CTR_MAX) ? m_ctr[i] + 1 : CTR_MAX;
                    m_target[i] = tgt;
                end else begin
                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end
            end else if (taken) begin
                m_valid[i] = 1; m_tag[i] = m_tagof(pc); m_target[i] = tgt; m_ctr[i] = CTR_MID;
            end
        end
    endtask

    task automatic model_check(input int n);
        int  i;
        bit  h;
        i = m_index(bpi.lookup_pc);
        h = m_valid[i] && (m_tag[i] == m_tagof(bpi.lookup_pc));
        check($sformatf("rnd%0d_hit", n), {31'd0, bpi.hit}, {31'd0, h});
        check($sformatf("rnd%0d_taken", n), {31'd0, bpi.predict_taken},
              {31'd0, h && (m_ctr[i] >= CTR_MID)});
        check($sformatf("rnd%0d_target", n), bpi.predict_target, h ? m_target[i] : 32'd0);
`ifdef BP_STATS_EN
        check($sformatf("rnd%0d_stat_upd", n), bpi.stat_updates, m_upd);
        check($sformatf("rnd%0d_stat_mis", n), bpi.stat_mispredicts, m_mis);
`endif
    endtask

    task automatic idle();
        bpi.update_en = 1'b0; bpi.update_pc = '0; bpi.update_taken = 1'b0;
        bpi.update_target = '0; bpi.update_mispredict = 1'b0; bpi.invalidate = 1'b0;
    endtask

    function automatic logic [31:0] rand_pc();
        return (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
               | 32'($urandom_range(0, 3));
    endfunction

    typedef struct {
        bit          upd;
        logic [31:0] upc;
        bit          utaken;
        logic [31:0] utgt;
        logic [31:0] lpc;
        bit          ehit;
        bit          etaken;
        logic [31:0] etgt;
    } vec_t;

    vec_t vecs [16];

    initial begin
        vecs[0]  = '{1'b0, 32'h0,  1'b0, 32'h0,   32'h40,       1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 32'h40, 1'b1, 32'h100, 32'h40,       1'b1, 1'b1, 32'h100};
        vecs[2]  = '{1'b1, 32'h40, 1'b0, 32'h0,   32'h40,       1'b1, 1'b0, 32'h100};
        vecs[3]  = '{1'b1, 32'h40, 1'b0, 32'h0,   32'h40,       1'b1, 1'b0, 32'h100};
        vecs[4]  = '{1'b1, 32'h40, 1'b0, 32'h0,   32'h40,       1'b1, 1'b0, 32'h100};
        vecs[5]  = '{1'b1, 32'h40, 1'b1, 32'h104, 32'h40,       1'b1, 1'b0, 32'h104};
        vecs[6]  = '{1'b1, 32'h40, 1'b1, 32'h100, 32'h40,       1'b1, 1'b1, 32'h100};
        vecs[7]  = '{1'b1, 32'h80, 1'b1, 32'h200, 32'h40,       1'b0, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 32'h0,  1'b0, 32'h0,   32'h80,       1'b1, 1'b1, 32'h200};
        vecs[9]  = '{1'b1, 32'h84, 1'b0, 32'h0,   32'h84,       1'b0, 1'b0, 32'h0};
        vecs[10] = '{1'b1, 32'h80, 1'b1, 32'h300, 32'h80,       1'b1, 1'b1, 32'h300};
        vecs[11] = '{1'b1, 32'h80, 1'b1, 32'h300, 32'h80,       1'b1, 1'b1, 32'h300};
        vecs[12] = '{1'b1, 32'h80, 1'b0, 32'h0,   32'h80,       1'b1, 1'b1, 32'h300};
        vecs[13] = '{1'b1, 32'h80, 1'b0, 32'h0,   32'h80,       1'b1, 1'b0, 32'h300};
        vecs[14] = '{1'b0, 32'h0,  1'b0, 32'h0,   32'h81,       1'b1, 1'b0, 32'h300};
        vecs[15] = '{1'b0, 32'h0,  1'b0, 32'h0,   32'h8000_0080, 1'b0, 1'b0, 32'h0};

        idle();
        bpi.lookup_pc = 32'h40;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hit", {31'd0, bpi.hit}, 32'd0);
        check("reset_target", bpi.predict_target, 32'd0);
        nrst = 1'b1;

        for (int i = 0; i < 16; i++) begin
            bpi.update_en = vecs[i].upd; bpi.update_pc = vecs[i].upc;
            bpi.update_taken = vecs[i].utaken; bpi.update_target = vecs[i].utgt;
            @(posedge clk);
            #1;
            idle();
            bpi.lookup_pc = vecs[i].lpc;
            #1;
            check($sformatf("vec%0d_hit", i), {31'd0, bpi.hit}, {31'd0, vecs[i].ehit});
            check($sformatf("vec%0d_taken", i), {31'd0, bpi.predict_taken}, {31'd0, vecs[i].etaken});
            check($sformatf("vec%0d_target", i), bpi.predict_target, vecs[i].etgt);
        end

        // Same-cycle update and lookup: old contents now, new contents next cycle.
        bpi.lookup_pc = 32'h44;
        bpi.update_en = 1'b1; bpi.update_pc = 32'h44; bpi.update_taken = 1'b1;
        bpi.update_target = 32'h500;
        #1;
        check("same_cycle_hit_before", {31'd0, bpi.hit}, 32'd0);
        @(posedge clk);
        #1;
        idle();
        #1;
        check("same_cycle_hit_after", {31'd0, bpi.hit}, 32'd1);
        check("same_cycle_target_after", bpi.predict_target, 32'h500);

        // Invalidate wins over a same-cycle update.
        bpi.invalidate = 1'b1;
        bpi.update_en = 1'b1; bpi.update_pc = 32'hC0; bpi.update_taken = 1'b1;
        bpi.update_target = 32'h600;
        @(posedge clk);
        #1;
        idle();
        begin
            logic [31:0] pcs [4];
            pcs = '{32'h40, 32'h80, 32'h44, 32'hC0};
            for (int k = 0; k < 4; k++) begin
                bpi.lookup_pc = pcs[k];
                #1;
                check($sformatf("inval_miss_%h", pcs[k]), {31'd0, bpi.hit}, 32'd0);
            end
        end

`ifdef BP_STATS_EN
        nrst = 1'b0;
        #1;
        nrst = 1'b1;
        check("stat_upd_zero", bpi.stat_updates, 32'd0);
        @(posedge clk);
        #1;
        for (int k = 0; k < 6; k++) begin
            bpi.update_en = 1'b1; bpi.update_pc = 32'h100 + 32'(k * 4);
            bpi.update_taken = k[0]; bpi.update_target = 32'h700;
            bpi.update_mispredict = (k == 1 || k == 3 || k == 5);
            bpi.invalidate = (k == 5);
            @(posedge clk);
            #1;
        end
        idle();
        check("stat_updates_5", bpi.stat_updates, 32'd5);
        check("stat_mispredicts_2", bpi.stat_mispredicts, 32'd2);
`endif

        // Asynchronous reset asserted in the middle of an update cycle.
        bpi.update_en = 1'b1; bpi.update_pc = 32'h40; bpi.update_taken = 1'b1;
        bpi.update_target = 32'h800;
        @(posedge clk);
        #1;
        bpi.update_pc = 32'h80; bpi.update_target = 32'h900;
        bpi.lookup_pc = 32'h40;
        #1;
        check("pre_reset_hit", {31'd0, bpi.hit}, 32'd1);
        #1;
        nrst = 1'b0;
        #1;
        check("async_reset_hit", {31'd0, bpi.hit}, 32'd0);
        check("async_reset_target", bpi.predict_target, 32'd0);
`ifdef BP_STATS_EN
        check("async_reset_stat_upd", bpi.stat_updates, 32'd0);
        check("async_reset_stat_mis", bpi.stat_mispredicts, 32'd0);
`endif
        @(posedge clk);
        #1;
        idle();
        nrst = 1'b1;
        bpi.lookup_pc = 32'h80;
        #1;
        check("post_reset_miss", {31'd0, bpi.hit}, 32'd0);
        check("post_reset_taken", {31'd0, bpi.predict_taken}, 32'd0);

        model_reset();
        for (int n = 0; n < 3000; n++) begin
            bit          en, tk, inv, mis;
            logic [31:0] upc, tgt;
            en  = ($urandom_range(0, 99) < 60);
            tk  = 1'($urandom_range(0, 1));
            inv = ($urandom_range(0, 99) < 2);
            mis = 1'($urandom_range(0, 1));
            upc = rand_pc();
            tgt = $urandom;
            bpi.lookup_pc = rand_pc();
            bpi.update_en = en; bpi.update_pc = upc; bpi.update_taken = tk;
            bpi.update_target = tgt; bpi.update_mispredict = mis; bpi.invalidate = inv;
            #2;
            model_check(n);
            @(posedge clk);
            model_update(en, inv, upc, tk, tgt, mis);
            #1;
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised direct-mapped branch target buffer with per-entry saturating direction counters. Next-generation replacement for the current fixed "resolve in ID, flush IF/ID" branch handling.
- Sits beside the program counter. IF looks up the fetch PC combinationally and steers next-PC. ID/EX resolution writes back outcome and target one update per cycle.
- Generalised in entry count, counter width and word width.

Parameters:
- ENTRIES, 16, number of BTB entries; power of two, 2..256.
- CTR_W, 2, direction counter width in bits; 1..4.
- WORD_W, 32, address/target width.
- IDX_W, $clog2(ENTRIES), index width (localparam, derived).
- TAG_W, WORD_W-IDX_W-2, tag width (localparam, derived).

Ports:
- CLK  in  1  clock, all state updates on rising edge
- nRST  in  1  asynchronous active-low reset
- lookup_pc  in  WORD_W  fetch PC from IF
- hit  out  1  valid entry with matching tag for lookup_pc
- predict_taken  out  1  hit AND counter MSB set
- predict_target  out  WORD_W  stored target; 0 when !hit
- update_en  in  1  resolution write strobe, one per cycle
- update_pc  in  WORD_W  PC of resolved branch/jump
- update_taken  in  1  actual outcome
- update_target  in  WORD_W  actual target, used only when update_taken=1
- update_mispredict  in  1  resolution disagreed with prediction; statistics only
- invalidate  in  1  clear all valid bits

Behaviour:
- Addressing:
  - index = pc[IDX_W+1:2]
  - tag = pc[WORD_W-1:IDX_W+2]
  - pc[1:0] ignored.
- Lookup:
  - Purely combinational, zero latency.
  - hit = valid[idx] && tag[idx]==lookup tag.
  - On !hit: predict_taken=0, predict_target=0.
- Counter encoding: 0 = strong not-taken up to 2^CTR_W-1 = strong taken. Taken means the MSB is set.
  - Update increments on taken, decrements on not-taken.
  - Saturates at both ends; no wrap.
- Update, registered, takes effect at the next rising edge when update_en=1:
  - Hit, taken: counter++ (saturating); target overwritten with update_target.
  - Hit, not-taken: counter-- (saturating); target unchanged.
  - Miss, taken: allocate. valid=1, tag written, target written, counter = 2^(CTR_W-1) (weakly taken). Any prior occupant is replaced.
  - Miss, not-taken: no state change.
- Simultaneous lookup and update to the same index:
  - Lookup returns pre-update contents; no bypass.
  - The new value is visible on the following cycle.
- invalidate=1:
  - All valid bits cleared at the next edge.
  - Has priority over a same-cycle update_en; that update is dropped.
  - Tags, targets and counters are left unchanged.
- Reset:
  - Asserting nRST low clears all valid bits immediately, without waiting for a clock edge. This includes assertion mid-update.
  - All counters reset to 2^(CTR_W-1)-1 (weakly not-taken).
  - Tags and targets reset to 0.
  - Outputs during and after reset: hit=0, predict_taken=0, predict_target=0.
- Timing: one write port, no multi-cycle operations. Throughput is one lookup plus one update per cycle.

Optional Feature:
- Macro: BP_STATS_EN.
- Defined: adds outputs stat_updates (32 bits) and stat_mispredicts (32 bits).
  - stat_updates increments on every accepted update_en (not dropped by invalidate).
  - stat_mispredicts increments when an accepted update also has update_mispredict=1.
  - Both wrap modulo 2^32 and reset to 0 on nRST.
  - Neither is cleared by invalidate.
- Undefined: ports and counters are absent; update_mispredict is ignored.

Decomposition:
- Shared package bp_types_pkg, containing:
  - typedef of the entry struct {valid, tag, target, ctr}
  - a function for CTR_W-generic saturating increment/decrement
  - constants for the reset and allocate counter values
- One sub-module: sat_counter. Parametrised CTR_W, with en and up inputs; instantiated per entry or inlined via the package function.

Test Plan:
- Reset then lookup_pc=0x0000_0040 -> hit=0, predict_taken=0, predict_target=0.
- Update 0x40 taken, target 0x100; next cycle lookup 0x40 -> hit=1, predict_taken=1, predict_target=0x100. With CTR_W=2 the counter is 2.
- Two not-taken updates to 0x40 -> counter 2 to 1 to 0; predict_taken=0 after the first. A third not-taken update holds the counter at 0 (saturation).
- Alias test, ENTRIES=16: allocate 0x40 (target 0x100), then taken update 0x80 (same index 0, different tag, target 0x200):
  - lookup 0x40 -> hit=0
  - lookup 0x80 -> target 0x200
- Same-cycle update and lookup on 0x44 from empty -> hit=0 that cycle, hit=1 the next. Invalidate plus update in the same cycle -> all lookups miss afterwards.
- With BP_STATS_EN defined: 5 updates, 2 with update_mispredict -> stat_updates=5, stat_mispredicts=2. Async nRST pulse mid-sequence zeros both and all hits.
